// File: rtl/biriscv_frontend_recovery.sv
// Frontend recovery sequencer: on a frontend error it stalls fetch, drains the backend,
// flushes the icache and redirects fetch to the replay PC, escalating to a sticky fatal state.
module biriscv_frontend_recovery #(
    parameter logic [31:0] RESET_PC      = 32'h80000000,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned RETRY_W       = 2,
    parameter int unsigned DRAIN_TIMEOUT = 64,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned TIMER_W       = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               error_i,
    input  logic               commit_valid_i,
    input  logic [31:0]        commit_npc_i,
    input  logic [1:0]         commit_priv_i,
    input  logic               pipe_idle_i,
    output logic               fetch_stall_o,
    output logic               icache_flush_o,
    output logic               recover_request_o,
    output logic [31:0]        recover_pc_o,
    output logic [1:0]         recover_priv_o,
    output logic               busy_o,
    output logic               fatal_o,
    output logic [RETRY_W-1:0] retry_count_o
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        FLUSH,
        REDIRECT,
        SETTLE,
        FATAL
    } state_t;

    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);
    localparam logic [TIMER_W-1:0] DRAIN_LAST = TIMER_W'(DRAIN_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);

    state_t             state, state_next;
    logic [RETRY_W-1:0] retry, retry_next, retry_inc;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [31:0]        replay_pc;
    logic [1:0]         replay_priv;

    // Saturating increment so the counter can never wrap back to zero.
    assign retry_inc = (retry == RETRY_MAX) ? retry : retry + 1'b1;

    always_comb begin
        state_next = state;
        retry_next = retry;
        timer_next = timer;
        case (state)
            IDLE: begin
                if (error_i) begin
                    if (retry == RETRY_MAX) begin
                        state_next = FATAL;
                    end else begin
                        state_next = DRAIN;
                        retry_next = retry_inc;
                        timer_next = '0;
                    end
                end else if (commit_valid_i) begin
                    retry_next = '0;
                end
            end
            DRAIN: begin
                if (pipe_idle_i) begin
                    state_next = FLUSH;
                end else if (timer == DRAIN_LAST) begin
                    state_next = FATAL;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            FLUSH: begin
                state_next = REDIRECT;
            end
            REDIRECT: begin
                state_next = SETTLE;
                timer_next = '0;
            end
            SETTLE: begin
                if (error_i) begin
                    if (retry == RETRY_MAX) begin
                        state_next = FATAL;
                    end else begin
                        state_next = DRAIN;
                        retry_next = retry_inc;
                        timer_next = '0;
                    end
                end else if (timer == SETTLE_LAST) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            retry       <= '0;
            timer       <= '0;
            replay_pc   <= RESET_PC;
            replay_priv <= 2'b11;
        end else begin
            state <= state_next;
            retry <= retry_next;
            timer <= timer_next;
            // Commit lands in the same edge as any error transition, so replay uses the new PC.
            if (commit_valid_i && (state != FATAL)) begin
                replay_pc   <= commit_npc_i;
                replay_priv <= commit_priv_i;
            end
        end
    end

    always_comb begin
        fetch_stall_o     = 1'b0;
        icache_flush_o    = 1'b0;
        recover_request_o = 1'b0;
        fatal_o           = 1'b0;
        busy_o            = (state != IDLE);
        case (state)
            DRAIN:    fetch_stall_o = 1'b1;
            FLUSH: begin
                fetch_stall_o  = 1'b1;
                icache_flush_o = 1'b1;
            end
            REDIRECT: begin
                fetch_stall_o     = 1'b1;
                recover_request_o = 1'b1;
            end
            FATAL: begin
                fetch_stall_o = 1'b1;
                fatal_o       = 1'b1;
            end
            default: fetch_stall_o = 1'b0;
        endcase
    end

    assign recover_pc_o   = replay_pc;
    assign recover_priv_o = replay_priv;
    assign retry_count_o  = retry;

endmodule

// File: tb/tb_biriscv_frontend_recovery.sv
// Scoreboard bench for biriscv_frontend_recovery: a behavioural model predicts each cycle's
// outputs and every redirect target; a monitor compares them against the DUT.
module tb_biriscv_frontend_recovery;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        error = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_npc = '0;
    logic [1:0]  commit_priv = '0;
    logic        pipe_idle = 1'b0;
    logic        fetch_stall, icache_flush, recover_request, busy, fatal;
    logic [31:0] recover_pc;
    logic [1:0]  recover_priv;
    logic [1:0]  retry_count;

    biriscv_frontend_recovery #(
        .RESET_PC(32'h80000000),
        .MAX_RETRIES(3),
        .RETRY_W(2),
        .DRAIN_TIMEOUT(64),
        .SETTLE_CYCLES(8),
        .TIMER_W(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .error_i(error),
        .commit_valid_i(commit_valid),
        .commit_npc_i(commit_npc),
        .commit_priv_i(commit_priv),
        .pipe_idle_i(pipe_idle),
        .fetch_stall_o(fetch_stall),
        .icache_flush_o(icache_flush),
        .recover_request_o(recover_request),
        .recover_pc_o(recover_pc),
        .recover_priv_o(recover_priv),
        .busy_o(busy),
        .fatal_o(fatal),
        .retry_count_o(retry_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        req;
        logic        busy;
        logic        fatal;
        logic [1:0]  retry;
        logic [31:0] pc;
        logic [1:0]  priv;
    } obs_t;

    obs_t        exp_q[$];
    logic [33:0] redir_q[$];
    int          checks = 0;
    int          errors = 0;
    int          req_seen = 0;

    // Reference model: phase names plus plain integer counters.
    string       m_phase = "idle";
    logic [31:0] m_pc = 32'h80000000;
    logic [1:0]  m_priv = 2'b11;
    int          m_retry = 0;
    int          m_wait = 0;
    int          m_fatal_cycles = 0;

    function automatic void model_step(input logic r, input logic e, input logic cv,
                                       input logic [31:0] npc, input logic [1:0] pv,
                                       input logic idl);
        obs_t o;
        if (r) begin
            m_phase = "idle"; m_pc = 32'h80000000; m_priv = 2'b11; m_retry = 0; m_wait = 0;
        end else if (m_phase != "fatal") begin
            if (cv) begin m_pc = npc; m_priv = pv; end
            if (m_phase == "idle" || m_phase == "settle") begin
                if (e) begin
                    if (m_retry >= 3) m_phase = "fatal";
                    else begin m_phase = "drain"; m_retry = m_retry + 1; m_wait = 0; end
                end else if (m_phase == "idle") begin
                    if (cv) m_retry = 0;
                end else begin
                    m_wait = m_wait + 1;
                    if (m_wait == 8) m_phase = "idle";
                end
            end else if (m_phase == "drain") begin
                m_wait = m_wait + 1;
                if (idl) m_phase = "flush";
                else if (m_wait == 64) m_phase = "fatal";
            end else if (m_phase == "flush") begin
                m_phase = "redirect";
            end else if (m_phase == "redirect") begin
                m_phase = "settle"; m_wait = 0;
            end
        end
        m_fatal_cycles = (m_phase == "fatal") ? m_fatal_cycles + 1 : 0;
        o.stall = (m_phase == "drain" || m_phase == "flush" || m_phase == "redirect" || m_phase == "fatal");
        o.flush = (m_phase == "flush");
        o.req   = (m_phase == "redirect");
        o.busy  = (m_phase != "idle");
        o.fatal = (m_phase == "fatal");
        o.retry = 2'(m_retry);
        o.pc    = m_pc;
        o.priv  = m_priv;
        exp_q.push_back(o);
        if (o.req) redir_q.push_back({m_pc, m_priv});
    endfunction

    task automatic cyc(input logic r, input logic e, input logic cv,
                       input logic [31:0] npc, input logic [1:0] pv, input logic idl);
        rst = r; error = e; commit_valid = cv; commit_npc = npc; commit_priv = pv; pipe_idle = idl;
        model_step(r, e, cv, npc, pv, idl);
        @(negedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    // Monitor: pops one expected observation per cycle and every predicted redirect.
    always @(negedge clk) begin
        obs_t act, exp;
        logic [33:0] rd;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = '{fetch_stall, icache_flush, recover_request, busy, fatal,
                    retry_count, recover_pc, recover_priv};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL outputs t=%0t got=%h expected=%h", $time, act, exp);
            end
            if (recover_request === 1'b1) begin
                req_seen++;
                checks++;
                if (redir_q.size() == 0) begin
                    errors++;
                    $display("FAIL redirect_unexpected got=%h expected=none", recover_pc);
                end else begin
                    rd = redir_q.pop_front();
                    if ({recover_pc, recover_priv} !== rd) begin
                        errors++;
                        $display("FAIL redirect_target got=%h expected=%h", {recover_pc, recover_priv}, rd);
                    end
                end
            end
        end
    end

    initial begin
        logic e, cv, idl, r;
        @(negedge clk);
        #1;

        // Basic recovery with replay PC from last commit, then forward progress clears retry.
        cyc(1, 0, 0, '0, 2'b00, 0);
        cyc(0, 0, 1, 32'h80000010, 2'b11, 0);
        cyc(0, 0, 1, 32'h80000014, 2'b11, 0);
        cyc(0, 1, 0, '0, 2'b00, 1);
        repeat (3) cyc(0, 0, 0, '0, 2'b00, 1);
        check_int("retry_after_first", int'(retry_count), 1);
        repeat (8) cyc(0, 0, 0, '0, 2'b00, 0);
        check_int("busy_after_settle", int'(busy), 0);
        cyc(0, 0, 1, 32'h80000018, 2'b11, 0);
        check_int("retry_cleared", int'(retry_count), 0);

        // Drain timeout escalates to fatal; reset recovers.
        cyc(0, 1, 0, '0, 2'b00, 0);
        repeat (64) cyc(0, 0, 0, '0, 2'b00, 0);
        check_int("fatal_after_timeout", int'(fatal), 1);
        repeat (3) cyc(0, 1, 1, 32'h12345678, 2'b01, 1);
        check_int("fatal_sticky", int'(fatal), 1);
        cyc(1, 0, 0, '0, 2'b00, 0);
        check_int("fatal_cleared", int'(fatal), 0);
        check_int("pc_after_reset", int'(recover_pc == 32'h80000000), 1);

        // Repeated errors without progress: three redirects then fatal.
        req_seen = 0;
        for (int unsigned k = 0; k < 4; k++) begin
            cyc(0, 1, 0, '0, 2'b00, 1);
            repeat (3) cyc(0, 0, 0, '0, 2'b00, 1);
        end
        check_int("redirect_count", req_seen, 3);
        check_int("fatal_on_fourth", int'(fatal), 1);
        cyc(1, 0, 0, '0, 2'b00, 0);

        // Same-cycle commit+error, and commit during drain.
        cyc(0, 1, 1, 32'h80000100, 2'b01, 1);
        repeat (12) cyc(0, 0, 0, '0, 2'b00, 0);
        cyc(0, 1, 0, '0, 2'b00, 0);
        cyc(0, 0, 1, 32'h80000104, 2'b00, 0);
        repeat (12) cyc(0, 0, 0, '0, 2'b00, 1);

        // Error held high through drain/flush/redirect re-enters drain from settle.
        cyc(1, 0, 0, '0, 2'b00, 0);
        repeat (5) cyc(0, 1, 0, '0, 2'b00, 1);
        check_int("retry_held_error", int'(retry_count), 2);
        repeat (12) cyc(0, 0, 0, '0, 2'b00, 1);

        // Reset while flushing.
        cyc(0, 1, 0, '0, 2'b00, 1);
        cyc(0, 0, 0, '0, 2'b00, 1);
        check_int("in_flush", int'(icache_flush), 1);
        cyc(1, 0, 0, '0, 2'b00, 1);
        check_int("flush_after_reset", int'(icache_flush), 0);
        check_int("retry_after_reset", int'(retry_count), 0);

        // Randomized traffic with occasional reset to leave fatal.
        for (int unsigned n = 0; n < 3000; n++) begin
            e   = ($urandom_range(99) < 8);
            cv  = ($urandom_range(99) < 40);
            idl = ($urandom_range(99) < 70);
            r   = ($urandom_range(999) < 3) || (m_fatal_cycles > 4);
            cyc(r, e, cv, $urandom() & 32'hFFFFFFFC, 2'($urandom_range(3)), idl);
        end

        cyc(0, 0, 0, '0, 2'b00, 0);
        check_int("redirects_drained", redir_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
